// File: rtl/irq_controller.sv
// Interrupt controller: polled arbitration of NMI + NUM_IRQ maskable channels with one-level NMI nesting.
// Build option IRQ_CTRL_EDGE_EN: edge-captured pending bits cleared on grant; default is level-sampled pending.
module irq_controller #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE  = 32'h10,
  parameter logic [31:0] NMI_VECTOR  = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi,
  input  logic               int_disable,
  input  logic               poll,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               eoi,
  output logic               resp_valid,
  output logic               take,
  output logic               take_nmi,
  output logic [31:0]        vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic [1:0]         in_service
);

  typedef enum logic [1:0] {IDLE, IRQ_SVC, NMI_SVC} state_t;

  state_t             state, state_nxt;
  logic               nested, nested_nxt;
  logic               nmi_pend, nmi_prev;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic               irq_hit;
  logic [4:0]         irq_idx;
  logic               nmi_grant, irq_grant;
  logic [31:0]        vec_nxt;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] grant_clr;
`endif

  always_comb begin
    eligible = pending & mask;
    irq_hit  = 1'b0;
    irq_idx  = '0;
    // Scan downward so the lowest set index is the one left standing.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        irq_hit = 1'b1;
        irq_idx = 5'(i);
      end
    end

    nmi_grant = poll && nmi_pend && (state != NMI_SVC);
    irq_grant = poll && !nmi_grant && (state == IDLE) && !int_disable && irq_hit;

    if (nmi_grant)      vec_nxt = NMI_VECTOR;
    else if (irq_grant) vec_nxt = VECTOR_BASE + 32'(irq_idx) * VEC_STRIDE;
    else                vec_nxt = '0;

`ifdef IRQ_CTRL_EDGE_EN
    grant_clr   = irq_grant ? (NUM_IRQ'(1) << irq_idx) : '0;
    // A fresh edge on a bit being granted keeps it set.
    pending_nxt = (pending & ~grant_clr) | (irq & ~irq_prev);
`else
    pending_nxt = irq;
`endif
  end

  // Next-state: eoi retires first, then a grant (decided on pre-eoi state) overrides.
  always_comb begin
    state_nxt  = state;
    nested_nxt = nested;
    if (eoi) begin
      case (state)
        NMI_SVC: begin
          state_nxt  = nested ? IRQ_SVC : IDLE;
          nested_nxt = 1'b0;
        end
        IRQ_SVC: state_nxt = IDLE;
        default: ;
      endcase
    end
    if (nmi_grant) begin
      state_nxt  = NMI_SVC;
      nested_nxt = (state == IRQ_SVC);
    end else if (irq_grant) begin
      state_nxt  = IRQ_SVC;
      nested_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      nested     <= 1'b0;
      pending    <= '0;
      mask       <= '0;
      nmi_pend   <= 1'b0;
      nmi_prev   <= 1'b0;
      resp_valid <= 1'b0;
      take       <= 1'b0;
      take_nmi   <= 1'b0;
      vector     <= '0;
`ifdef IRQ_CTRL_EDGE_EN
      irq_prev   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      nested     <= nested_nxt;
      pending    <= pending_nxt;
      if (mask_we) mask <= mask_wdata;
      nmi_pend   <= (nmi_pend & ~nmi_grant) | (nmi & ~nmi_prev);
      nmi_prev   <= nmi;
      resp_valid <= poll;
      take       <= nmi_grant | irq_grant;
      take_nmi   <= nmi_grant;
      vector     <= vec_nxt;
`ifdef IRQ_CTRL_EDGE_EN
      irq_prev   <= irq;
`endif
    end
  end

  assign in_service = {state == NMI_SVC, (state == IRQ_SVC) || ((state == NMI_SVC) && nested)};

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of maskable interrupt channels (1..32).
REQ-002 Parameter VECTOR_BASE, default 32'h0000_0100, vector of channel 0.
REQ-003 Parameter VEC_STRIDE, default 32'h10, vector spacing between channels.
REQ-004 Parameter NMI_VECTOR, default 32'h0000_0080, NMI vector.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 irq  in  NUM_IRQ  maskable requests, synchronous to clk.
REQ-008 nmi  in  1  non-maskable request, synchronous to clk.
REQ-009 int_disable  in  1  global maskable-interrupt disable from the CPU.
REQ-010 poll  in  1  one-cycle pulse from the CPU controller at an instruction boundary.
REQ-011 mask_we / mask_wdata  in  1 / NUM_IRQ  mask register write; bit=1 enables channel.
REQ-012 eoi  in  1  end-of-interrupt pulse from the handler.
REQ-013 resp_valid  out  1  poll response strobe.
REQ-014 take / take_nmi  out  1 / 1  interrupt granted / grant is NMI.
REQ-015 vector  out  32  handler address, valid with resp_valid&take.
REQ-016 pending / mask  out  NUM_IRQ  pending and mask register contents.
REQ-017 in_service  out  2  {nmi_active, irq_active}.

Function
REQ-018 States: IDLE, IRQ_SVC, NMI_SVC; NMI_SVC carries a one-bit flag nested (IRQ_SVC was preempted).
REQ-019 nmi rising edge sets nmi_pend; nmi_pend is cleared only by an NMI grant or rst.
REQ-020 resp_valid is high exactly one cycle after each poll cycle; take, take_nmi, vector are registered and valid in that cycle, zero otherwise.
REQ-021 Poll arbitration uses register values of the poll cycle: nmi_pend wins in IDLE or IRQ_SVC; else, in IDLE with int_disable=0, lowest-index set bit of pending&mask wins; else take=0.
REQ-022 NMI grant: take=1, take_nmi=1, vector=NMI_VECTOR, nmi_pend cleared, next state NMI_SVC, nested=1 if granted from IRQ_SVC.
REQ-023 IRQ grant of channel i: take=1, take_nmi=0, vector=VECTOR_BASE+i*VEC_STRIDE (32-bit, wrap on overflow), next state IRQ_SVC.
REQ-024 No grant of any kind from NMI_SVC; no IRQ grant from IRQ_SVC.
REQ-025 eoi in NMI_SVC -> IRQ_SVC if nested else IDLE; eoi in IRQ_SVC -> IDLE; eoi in IDLE ignored.
REQ-026 eoi and poll in same cycle: poll arbitrates against pre-eoi state; eoi transition applies; grant transition overrides only if a grant occurs.
REQ-027 mask_we updates mask next cycle; a poll in the same cycle uses the old mask.
REQ-028 New set condition and grant-clear on the same bit in the same cycle: bit stays set.
REQ-029 Unused upper bits of any width-32 calculation are zero; NUM_IRQ=1 is legal.

Reset
REQ-030 rst=1: state IDLE, nested=0, pending=0, nmi_pend=0, mask=0, resp_valid=0, take=0, take_nmi=0, vector=0, in_service=2'b00, edge-detect history=0.
REQ-031 rst mid-service or mid-response drops the response; no resp_valid in the cycle after rst.

Configuration
REQ-032 Macro IRQ_CTRL_EDGE_EN defined: pending[i] set on rising edge of irq[i], cleared on grant of i.
REQ-033 IRQ_CTRL_EDGE_EN undefined: pending = irq registered each cycle (level), no grant clear; NMI remains edge-detected in both builds.

Verification
REQ-034 rst, mask=8'hFF, irq=8'b0001_0100 edge, poll -> next cycle resp_valid=1, take=1, vector=32'h120, pending=8'b0001_0000.
REQ-035 IRQ_SVC, nmi edge, poll -> take_nmi=1, vector=32'h80, in_service=2'b11; eoi -> 2'b01; eoi -> 2'b00.
REQ-036 int_disable=1, irq[0] pending, poll -> take=0; nmi edge, poll -> take_nmi=1.
REQ-037 mask=0 with pending=8'hFF, poll -> take=0; mask_we with 8'h80 and poll same cycle -> take=0; next poll -> vector=32'h170.
REQ-038 rst asserted in NMI_SVC with pending nonzero -> all outputs zero next cycle; poll -> take=0.
